// File: rtl/bpred_resolve_queue_pkg.sv
// Shared definitions for the branch-prediction resolve queue.
// Purpose: entry layout and field widths that the predictor and the resolve
//          queue must agree on.
// Contents: BIMODAL_W, CARRY_W, BPRED_ENTRY_W and the bit offset of each field
//           inside a packed entry {pc4, pred_dir, pred_target, bimodal, carry}.
package bpred_resolve_queue_pkg;

    localparam int unsigned PC_W          = 32;
    localparam int unsigned BIMODAL_W     = 12;
    localparam int unsigned CARRY_W       = 44;
    localparam int unsigned BPRED_ENTRY_W = PC_W + 1 + PC_W + BIMODAL_W + CARRY_W;  // 121

    // Field offsets, LSB first.
    localparam int unsigned CARRY_LSB       = 0;
    localparam int unsigned BIMODAL_LSB     = CARRY_LSB + CARRY_W;        // 44
    localparam int unsigned PRED_TARGET_LSB = BIMODAL_LSB + BIMODAL_W;    // 56
    localparam int unsigned PRED_DIR_BIT    = PRED_TARGET_LSB + PC_W;     // 88
    localparam int unsigned PC4_LSB         = PRED_DIR_BIT + 1;           // 89

endpackage

// File: rtl/bpred_entry_fifo.sv
// Generic circular buffer with push, pop and flush.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   flush_i      - clears pointers and count; a push in the same cycle is dropped
//   push_i/pop_i - enqueue wdata_i / dequeue the head (caller guarantees legality)
//   wdata_i      - entry to enqueue
//   rdata_o      - current head entry (combinational read)
//   count_o      - number of stored entries
//   full_o/empty_o
module bpred_entry_fifo #(
    parameter int unsigned WIDTH = 121,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PTR_W bits wide, so increments wrap at DEPTH.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/bpred_resolve_queue.sv
// In-order queue of branch-prediction metadata between fetch and execute.
// Fetch pushes one prediction per cycle; execute resolves the oldest entry.
// One cycle after a resolve the predictor update interface is driven, and on a
// misprediction a one-cycle redirect is raised and all younger entries flushed.
// Ports:
//   f_*            - fetch push interface (f_ready = room or pop this cycle)
//   ex_*, stall    - execute resolve interface (ex_ready = !empty && !stall)
//   upd_*          - registered predictor update (upd_valid only for branches)
//   redirect_*     - registered fetch redirect pulse and target
//   occupancy, resolve_count, miss_count, underflow_err - status
module bpred_resolve_queue
    import bpred_resolve_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_valid,
    input  logic [31:0]          f_pc4,
    input  logic                 f_pred_dir,
    input  logic [31:0]          f_pred_target,
    input  logic [BIMODAL_W-1:0] f_bimodal,
    input  logic [CARRY_W-1:0]   f_carry,
    output logic                 f_ready,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic                 ex_dir,
    input  logic [31:0]          ex_target,
    output logic                 ex_ready,
    input  logic                 stall,
    output logic                 upd_valid,
    output logic [31:0]          upd_pc4,
    output logic [31:0]          upd_target,
    output logic                 upd_dir,
    output logic                 upd_miss,
    output logic [BIMODAL_W-1:0] upd_bimodal,
    output logic [CARRY_W-1:0]   upd_carry,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [PTR_W:0]       occupancy,
    output logic [CNT_W-1:0]     resolve_count,
    output logic [CNT_W-1:0]     miss_count,
    output logic                 underflow_err
);

    logic [BPRED_ENTRY_W-1:0] wr_entry, head;
    logic                     empty, full, pop, push, miss, flush;

    logic [31:0]          head_pc4, head_pred_target;
    logic                 head_pred_dir;
    logic [BIMODAL_W-1:0] head_bimodal;
    logic [CARRY_W-1:0]   head_carry;

    assign wr_entry = {f_pc4, f_pred_dir, f_pred_target, f_bimodal, f_carry};

    assign head_pc4         = head[PC4_LSB +: 32];
    assign head_pred_dir    = head[PRED_DIR_BIT];
    assign head_pred_target = head[PRED_TARGET_LSB +: 32];
    assign head_bimodal     = head[BIMODAL_LSB +: BIMODAL_W];
    assign head_carry       = head[CARRY_LSB +: CARRY_W];

    assign pop      = ex_valid && !empty && !stall;
    assign f_ready  = !full || pop;
    assign push     = f_valid && f_ready;
    assign ex_ready = !empty && !stall;

    // A non-branch that was predicted taken sent fetch down a bogus path.
    always_comb begin
        if (ex_is_branch) begin
            miss = (ex_dir != head_pred_dir) || (ex_dir && (ex_target != head_pred_target));
        end else begin
            miss = head_pred_dir;
        end
    end

    assign flush = pop && miss;

    bpred_entry_fifo #(
        .WIDTH (BPRED_ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (occupancy),
        .full_o  (full),
        .empty_o (empty)
    );

    logic                 upd_valid_q, upd_valid_d;
    logic [31:0]          upd_pc4_q, upd_pc4_d;
    logic [31:0]          upd_target_q, upd_target_d;
    logic                 upd_dir_q, upd_dir_d;
    logic                 upd_miss_q, upd_miss_d;
    logic [BIMODAL_W-1:0] upd_bimodal_q, upd_bimodal_d;
    logic [CARRY_W-1:0]   upd_carry_q, upd_carry_d;
    logic                 redirect_valid_q, redirect_valid_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]     resolve_count_q, resolve_count_d;
    logic [CNT_W-1:0]     miss_count_q, miss_count_d;
    logic                 underflow_q, underflow_d;

    always_comb begin
        // Strobes drop every cycle; payload fields hold until the next pop.
        upd_valid_d      = 1'b0;
        redirect_valid_d = 1'b0;
        upd_pc4_d        = upd_pc4_q;
        upd_target_d     = upd_target_q;
        upd_dir_d        = upd_dir_q;
        upd_miss_d       = upd_miss_q;
        upd_bimodal_d    = upd_bimodal_q;
        upd_carry_d      = upd_carry_q;
        redirect_pc_d    = redirect_pc_q;
        resolve_count_d  = resolve_count_q;
        miss_count_d     = miss_count_q;
        underflow_d      = underflow_q || (ex_valid && empty);
        if (pop) begin
            upd_valid_d     = ex_is_branch;
            upd_dir_d       = ex_dir && ex_is_branch;
            upd_miss_d      = miss;
            upd_pc4_d       = head_pc4;
            upd_target_d    = ex_target;
            upd_bimodal_d   = head_bimodal;
            upd_carry_d     = head_carry;
            resolve_count_d = resolve_count_q + CNT_W'(1);
            if (miss) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = (ex_is_branch && ex_dir) ? ex_target : head_pc4;
                miss_count_d     = miss_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_q      <= 1'b0;
            upd_pc4_q        <= '0;
            upd_target_q     <= '0;
            upd_dir_q        <= 1'b0;
            upd_miss_q       <= 1'b0;
            upd_bimodal_q    <= '0;
            upd_carry_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            resolve_count_q  <= '0;
            miss_count_q     <= '0;
            underflow_q      <= 1'b0;
        end else begin
            upd_valid_q      <= upd_valid_d;
            upd_pc4_q        <= upd_pc4_d;
            upd_target_q     <= upd_target_d;
            upd_dir_q        <= upd_dir_d;
            upd_miss_q       <= upd_miss_d;
            upd_bimodal_q    <= upd_bimodal_d;
            upd_carry_q      <= upd_carry_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            resolve_count_q  <= resolve_count_d;
            miss_count_q     <= miss_count_d;
            underflow_q      <= underflow_d;
        end
    end

    assign upd_valid      = upd_valid_q;
    assign upd_pc4        = upd_pc4_q;
    assign upd_target     = upd_target_q;
    assign upd_dir        = upd_dir_q;
    assign upd_miss       = upd_miss_q;
    assign upd_bimodal    = upd_bimodal_q;
    assign upd_carry      = upd_carry_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign resolve_count  = resolve_count_q;
    assign miss_count     = miss_count_q;
    assign underflow_err  = underflow_q;

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Self-checking bench for bpred_resolve_queue: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_bpred_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_valid, f_pred_dir, f_ready;
    logic [31:0] f_pc4, f_pred_target;
    logic [11:0] f_bimodal;
    logic [43:0] f_carry;
    logic        ex_valid, ex_is_branch, ex_dir, ex_ready, stall;
    logic [31:0] ex_target;
    logic        upd_valid, upd_dir, upd_miss, redirect_valid, underflow_err;
    logic [31:0] upd_pc4, upd_target, redirect_pc, resolve_count, miss_count;
    logic [11:0] upd_bimodal;
    logic [43:0] upd_carry;
    logic [3:0]  occupancy;

    always #5 clk = ~clk;

    bpred_resolve_queue dut (
        .clk            (clk),
        .reset          (reset),
        .f_valid        (f_valid),
        .f_pc4          (f_pc4),
        .f_pred_dir     (f_pred_dir),
        .f_pred_target  (f_pred_target),
        .f_bimodal      (f_bimodal),
        .f_carry        (f_carry),
        .f_ready        (f_ready),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_dir         (ex_dir),
        .ex_target      (ex_target),
        .ex_ready       (ex_ready),
        .stall          (stall),
        .upd_valid      (upd_valid),
        .upd_pc4        (upd_pc4),
        .upd_target     (upd_target),
        .upd_dir        (upd_dir),
        .upd_miss       (upd_miss),
        .upd_bimodal    (upd_bimodal),
        .upd_carry      (upd_carry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy),
        .resolve_count  (resolve_count),
        .miss_count     (miss_count),
        .underflow_err  (underflow_err)
    );

    typedef struct {
        logic [31:0] pc4;
        logic        dir;
        logic [31:0] tgt;
        logic [11:0] bim;
        logic [43:0] carry;
    } ent_t;

    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;
    bit   model_on = 1'b0;

    logic        e_uv, e_rv, e_dir, e_miss, e_uf, e_popped;
    logic [31:0] e_pc4, e_tgt, e_rpc, e_rc, e_mc;
    logic [11:0] e_bim;
    logic [43:0] e_carry;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-order queue, updated from the inputs seen at each edge.
    always @(posedge clk) begin : model
        ent_t h;
        ent_t n;
        bit   m_pop, m_push, m_miss;
        int   sz;
        if (reset) begin
            mq.delete();
            e_uv = 0; e_rv = 0; e_dir = 0; e_miss = 0; e_uf = 0; e_popped = 0;
            e_pc4 = 0; e_tgt = 0; e_rpc = 0; e_rc = 0; e_mc = 0; e_bim = 0; e_carry = 0;
        end else begin
            sz     = mq.size();
            m_pop  = ex_valid && sz > 0 && !stall;
            m_push = f_valid && (sz < 8 || m_pop);
            if (ex_valid && sz == 0) e_uf = 1;
            e_uv = 0;
            e_rv = 0;
            e_popped = m_pop;
            if (m_pop) begin
                h = mq.pop_front();
                if (ex_is_branch) m_miss = (ex_dir != h.dir) || (ex_dir && ex_target != h.tgt);
                else              m_miss = h.dir;
                e_uv    = ex_is_branch;
                e_dir   = ex_dir && ex_is_branch;
                e_miss  = m_miss;
                e_pc4   = h.pc4;
                e_bim   = h.bim;
                e_carry = h.carry;
                e_tgt   = ex_target;
                e_rc    = e_rc + 1;
                if (m_miss) begin
                    e_mc   = e_mc + 1;
                    e_rv   = 1;
                    e_rpc  = (ex_is_branch && ex_dir) ? ex_target : h.pc4;
                    mq.delete();
                    m_push = 0;
                end
            end
            if (m_push) begin
                n.pc4 = f_pc4; n.dir = f_pred_dir; n.tgt = f_pred_target;
                n.bim = f_bimodal; n.carry = f_carry;
                mq.push_back(n);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int  sz;
        bit  e_fr;
        if (model_on) begin
            sz   = mq.size();
            e_fr = (sz < 8) || (ex_valid && sz > 0 && !stall);
            chk("f_ready", 64'(f_ready), 64'(e_fr));
            chk("ex_ready", 64'(ex_ready), 64'(sz > 0 && !stall));
            chk("occupancy", 64'(occupancy), 64'(sz));
            chk("upd_valid", 64'(upd_valid), 64'(e_uv));
            chk("redirect_valid", 64'(redirect_valid), 64'(e_rv));
            chk("resolve_count", 64'(resolve_count), 64'(e_rc));
            chk("miss_count", 64'(miss_count), 64'(e_mc));
            chk("underflow_err", 64'(underflow_err), 64'(e_uf));
            if (e_popped) begin
                chk("upd_dir", 64'(upd_dir), 64'(e_dir));
                chk("upd_miss", 64'(upd_miss), 64'(e_miss));
                chk("upd_pc4", 64'(upd_pc4), 64'(e_pc4));
                chk("upd_target", 64'(upd_target), 64'(e_tgt));
                chk("upd_bimodal", 64'(upd_bimodal), 64'(e_bim));
                chk("upd_carry", 64'(upd_carry), 64'(e_carry));
            end
            if (e_rv) chk("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_valid = 0; ex_valid = 0; ex_is_branch = 0; ex_dir = 0; stall = 0;
    endtask

    task automatic set_push(input logic [31:0] pc4, input logic dir, input logic [31:0] tgt);
        f_valid = 1; f_pc4 = pc4; f_pred_dir = dir; f_pred_target = tgt;
        f_bimodal = pc4[13:2]; f_carry = {12'hA5C, pc4};
    endtask

    task automatic do_push(input logic [31:0] pc4, input logic dir, input logic [31:0] tgt);
        set_push(pc4, dir, tgt);
        step();
        f_valid = 0;
    endtask

    task automatic do_resolve(input logic br, input logic d, input logic [31:0] tgt);
        ex_valid = 1; ex_is_branch = br; ex_dir = d; ex_target = tgt;
        step();
        ex_valid = 0; f_valid = 0;
    endtask

    initial begin
        f_pc4 = 0; f_pred_dir = 0; f_pred_target = 0; f_bimodal = 0; f_carry = 0;
        ex_target = 0;
        idle();
        reset = 1;
        step();
        model_on = 1;
        step();
        reset = 0;
        chk("rst_f_ready", 64'(f_ready), 64'd1);
        chk("rst_ex_ready", 64'(ex_ready), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rst_upd_pc4", 64'(upd_pc4), 64'd0);

        // Three correctly predicted taken branches.
        for (int i = 0; i < 3; i++) do_push(32'h10 + 32'(4 * i), 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) begin
            do_resolve(1'b1, 1'b1, 32'h40);
            chk("hit_upd_valid", 64'(upd_valid), 64'd1);
            chk("hit_upd_miss", 64'(upd_miss), 64'd0);
            chk("hit_upd_pc4", 64'(upd_pc4), 64'(32'h10 + 32'(4 * i)));
        end
        step();
        chk("hit_resolve_count", 64'(resolve_count), 64'd3);
        chk("hit_occupancy", 64'(occupancy), 64'd0);

        // Predicted not-taken, actually taken; the push in the same cycle is dropped.
        do_push(32'h104, 1'b0, 32'h108);
        set_push(32'h500, 1'b0, 32'h0);
        do_resolve(1'b1, 1'b1, 32'h200);
        chk("miss_redirect_valid", 64'(redirect_valid), 64'd1);
        chk("miss_redirect_pc", 64'(redirect_pc), 64'h200);
        chk("miss_upd_miss", 64'(upd_miss), 64'd1);
        chk("miss_upd_dir", 64'(upd_dir), 64'd1);
        chk("miss_occupancy", 64'(occupancy), 64'd0);
        chk("miss_count", 64'(miss_count), 64'd1);
        step();
        chk("redirect_one_cycle", 64'(redirect_valid), 64'd0);

        // Fill, then push and pop together at full.
        for (int i = 0; i < 8; i++) do_push(32'h300 + 32'(4 * i), 1'b1, 32'h40);
        chk("full_f_ready", 64'(f_ready), 64'd0);
        set_push(32'h400, 1'b1, 32'h40);
        do_resolve(1'b1, 1'b1, 32'h40);
        chk("full_occupancy", 64'(occupancy), 64'd8);
        chk("full_upd_pc4", 64'(upd_pc4), 64'h300);
        for (int i = 0; i < 8; i++) do_resolve(1'b1, 1'b1, 32'h40);
        chk("wrap_last_pc4", 64'(upd_pc4), 64'h400);
        chk("wrap_occupancy", 64'(occupancy), 64'd0);

        // Stall holds the pop off.
        do_push(32'h600, 1'b1, 32'h40);
        do_push(32'h604, 1'b1, 32'h40);
        stall = 1; ex_valid = 1; ex_is_branch = 1; ex_dir = 1; ex_target = 32'h40;
        repeat (3) step();
        chk("stall_upd_valid", 64'(upd_valid), 64'd0);
        chk("stall_occupancy", 64'(occupancy), 64'd2);
        chk("stall_ex_ready", 64'(ex_ready), 64'd0);
        stall = 0;
        step();
        ex_valid = 0;
        chk("unstall_upd_valid", 64'(upd_valid), 64'd1);
        chk("unstall_upd_pc4", 64'(upd_pc4), 64'h600);
        do_resolve(1'b1, 1'b1, 32'h40);

        // Non-branches: predicted not-taken is fine, predicted taken redirects to pc4.
        do_push(32'h700, 1'b0, 32'h0);
        do_resolve(1'b0, 1'b0, 32'h0);
        chk("nb_upd_valid", 64'(upd_valid), 64'd0);
        chk("nb_redirect", 64'(redirect_valid), 64'd0);
        do_push(32'h704, 1'b1, 32'h800);
        do_push(32'h708, 1'b1, 32'h900);
        do_resolve(1'b0, 1'b0, 32'h0);
        chk("nb_miss_redirect", 64'(redirect_valid), 64'd1);
        chk("nb_miss_redirect_pc", 64'(redirect_pc), 64'h704);
        chk("nb_flush_occupancy", 64'(occupancy), 64'd0);
        chk("nb_miss_count", 64'(miss_count), 64'd2);

        // Underflow is sticky; reset clears everything mid-run.
        do_resolve(1'b1, 1'b1, 32'h0);
        chk("underflow_set", 64'(underflow_err), 64'd1);
        step();
        step();
        chk("underflow_sticky", 64'(underflow_err), 64'd1);
        for (int i = 0; i < 5; i++) do_push(32'hA00 + 32'(4 * i), 1'b1, 32'h40);
        chk("pre_reset_occupancy", 64'(occupancy), 64'd5);
        reset = 1;
        step();
        reset = 0;
        chk("mid_reset_occupancy", 64'(occupancy), 64'd0);
        chk("mid_reset_underflow", 64'(underflow_err), 64'd0);
        chk("mid_reset_resolve_count", 64'(resolve_count), 64'd0);
        chk("mid_reset_miss_count", 64'(miss_count), 64'd0);
        chk("mid_reset_ex_ready", 64'(ex_ready), 64'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
